// File: rtl/tx_buffer_pkg.sv
// Shared types for the transmit byte path.
// TX_BUFFER_LE_EN selects LSB-first byte order; MSB-first when undefined.
package tx_buffer_pkg;

  typedef enum logic {IDLE, SEND} tx_state_t;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned IDX_W          = $clog2(BYTES_PER_WORD);

  typedef logic [31:0] word_t;
  typedef logic [7:0]  byte_t;

  // Byte idx of a word in transmit order.
  function automatic byte_t byte_sel(input word_t w, input logic [IDX_W-1:0] idx);
    byte_t b;
`ifdef TX_BUFFER_LE_EN
    case (idx)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
`else
    case (idx)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
`endif
    return b;
  endfunction

endpackage

// File: rtl/transmitter_buffer_word_fifo.sv
// Synchronous word FIFO with occupancy count; pushes when full and pops when empty are ignored.
module word_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [PTR_W:0]   o_count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rd_ptr];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/transmitter_buffer.sv
// Queues 32-bit words and serialises each into 4 bytes with a valid/ready handshake.
// TX_BUFFER_LE_EN (in tx_buffer_pkg) selects LSB-first byte order.
module transmitter_buffer
  import tx_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic [31:0] output_data,
  input  logic        we,
  output logic        full,
  output logic        busy,
  output logic [7:0]  data,
  output logic        valid,
  input  logic        tx_ready
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  tx_state_t        r_state;
  logic [IDX_W-1:0] r_idx;
  word_t            r_shift;
  byte_t            r_data;
  logic             r_valid;

  word_t            w_head;
  logic             w_empty;
  logic             w_full;
  logic [PTR_W:0]   w_count;
  logic             w_handshake;
  logic             w_last;
  logic             w_pop;

  word_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .i_clk     (CLK),
    .i_rstn    (RSTN),
    .i_push    (we),
    .i_wr_data (output_data),
    .i_pop     (w_pop),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_count)
  );

  assign w_handshake = (r_state == SEND) && tx_ready;
  assign w_last      = w_handshake && (r_idx == LAST_IDX);
  // Load a new word when idle, or right after the last byte so words go out back-to-back.
  assign w_pop       = ((r_state == IDLE) || w_last) && !w_empty;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (w_pop) begin
      r_state <= SEND;
      r_idx   <= '0;
      r_shift <= w_head;
      r_data  <= byte_sel(w_head, '0);
      r_valid <= 1'b1;
    end else if (w_last) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
    end else if (w_handshake) begin
      r_idx  <= r_idx + 1'b1;
      r_data <= byte_sel(r_shift, r_idx + 1'b1);
    end
  end

  assign full  = w_full;
  assign busy  = (w_count != '0) || (r_state == SEND);
  assign data  = r_data;
  assign valid = r_valid;

endmodule
